// File: rtl/puf_sched_pkg.sv
// puf_sched package: scheduler state encoding and default parameter values
// shared by the interface, the scheduler and its key front end.
package puf_pkg;

   // Scheduler present state, exported on the ps port
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      PAUSE = 3'd3,
      HALT  = 3'd4
   } sched_state_t;

   localparam int N_PUF_DEF   = 4;
   localparam int CW_DEF      = 8;
   localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/puf_sched_if.sv
// puf_sched_if: challenge/response bus between the scheduler (master) and
// the PUF array (slave). Carries the channel select, one-hot enable,
// challenge strobe/value and the response-valid pulse.
interface puf_sched_if
   import puf_pkg::*;
#(
   parameter int N_PUF = N_PUF_DEF,
   parameter int CW    = CW_DEF
) ();

   localparam int SEL_W = $clog2(N_PUF);

   logic [SEL_W-1:0] sel;
   logic [N_PUF-1:0] puf_en;
   logic             chal_vld;
   logic [CW-1:0]    chal;
   logic             rsp_vld;

   modport master (
      output sel, puf_en, chal_vld, chal,
      input  rsp_vld
   );

   modport slave (
      input  sel, puf_en, chal_vld, chal,
      output rsp_vld
   );

endinterface

// File: rtl/puf_sched_key_edge.sv
// key_edge: two-flop synchroniser for an active-low push button followed by
// a falling-edge detector. A press produces one registered pulse three
// cycles after the key falls; holding the key does not retrigger.
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   // sync_r[0..1] is the synchroniser, sync_r[2] the previous synced level
   logic [2:0] sync_r;

   // Synchronise the key and register a one-cycle pulse on its falling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= 3'b111;
         press  <= 1'b0;
      end else begin
         sync_r <= {sync_r[1:0], key_n};
         press  <= sync_r[2] & ~sync_r[1];
      end
   end

endmodule

// File: rtl/puf_sched.sv
// puf_sched: round-robin challenge scheduler for N_PUF PUF channels.
// Walks every channel through every CW-bit challenge value, one channel at a
// time, with a challenge strobe / response-valid handshake. Start and step
// come from debounced-free DE0_Nano keys (edge detected), or the schedule
// advances by itself in auto mode.
// Optional feature: define PUF_SCHED_TIMEOUT_EN to add a response watchdog
// that flags err_timeout and advances as if a response had arrived.
module puf_sched
   import puf_pkg::*;
#(
   parameter int N_PUF   = N_PUF_DEF,
   parameter int CW      = CW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                fsm_rst,
   input  logic                fsm_restart,
   input  logic [1:0]          KEY,
   input  logic                auto_mode,
   output sched_state_t        ps,
   output logic [N_PUF*CW-1:0] ch_cnt,
   output logic                done,
   output logic                err_timeout,
   puf_sched_if.master         bus
);

   localparam int               SEL_W    = $clog2(N_PUF);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_PUF - 1);
   localparam logic [CW-1:0]    CNT_MAX  = {CW{1'b1}};
   localparam logic [N_PUF-1:0] EN_ONE   = N_PUF'(1);

   sched_state_t     ps_r;
   logic [SEL_W-1:0] sel_r;
   logic [N_PUF-1:0] puf_en_r;
   logic             chal_vld_r;
   logic             done_r;
   logic [CW-1:0]    cnt_r [N_PUF];

   logic             start_p;
   logic             step_p;

   logic [CW-1:0]    cur_cnt_s;
   logic [CW-1:0]    inc_cnt_s;
   logic [SEL_W-1:0] sel_inc_s;
   logic             final_s;
   logic             accept_s;
   logic             timeout_s;

   key_edge u_key_start (
      .clk   (clk),
      .rst   (fsm_rst),
      .key_n (KEY[0]),
      .press (start_p)
   );

   key_edge u_key_step (
      .clk   (clk),
      .rst   (fsm_rst),
      .key_n (KEY[1]),
      .press (step_p)
   );

`ifdef PUF_SCHED_TIMEOUT_EN
   localparam int                WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_r;
   logic            err_r;

   // Watchdog fires in the TIMEOUT-th consecutive WAIT cycle without a response
   always_comb begin
      if ((ps_r == WAIT) && !bus.rsp_vld && (wd_r == WD_LAST)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Count WAIT cycles (zero outside WAIT) and latch the sticky timeout flag
   always_ff @(posedge clk or posedge fsm_rst) begin
      if (fsm_rst) begin
         wd_r  <= '0;
         err_r <= 1'b0;
      end else begin
         if (ps_r != WAIT) begin
            wd_r <= '0;
         end else if (!bus.rsp_vld) begin
            wd_r <= wd_r + WD_W'(1);
         end else begin
            wd_r <= wd_r;
         end
         if (timeout_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   assign err_timeout = err_r;
`else
   // Without the watchdog a WAIT only ends on a real response
   always_comb begin
      timeout_s = 1'b0;
   end

   assign err_timeout = 1'b0;
`endif

   // Next-counter, next-select and final-response decode for the active channel
   always_comb begin
      cur_cnt_s = cnt_r[sel_r];
      if (cur_cnt_s == CNT_MAX) begin
         inc_cnt_s = CNT_MAX;
      end else begin
         inc_cnt_s = cur_cnt_s + CW'(1);
      end
      if (sel_r == SEL_LAST) begin
         sel_inc_s = '0;
      end else begin
         sel_inc_s = sel_r + SEL_W'(1);
      end
      final_s  = (sel_r == SEL_LAST) && (cur_cnt_s == CNT_MAX);
      accept_s = (ps_r == WAIT) && (bus.rsp_vld || timeout_s);
   end

   // Scheduler FSM: state, select, counters and all registered handshake outputs
   always_ff @(posedge clk or posedge fsm_rst) begin
      if (fsm_rst) begin
         ps_r       <= IDLE;
         sel_r      <= '0;
         puf_en_r   <= '0;
         chal_vld_r <= 1'b0;
         done_r     <= 1'b0;
         for (int k = 0; k < N_PUF; k++) begin
            cnt_r[k] <= '0;
         end
      end else begin
         chal_vld_r <= 1'b0;
         done_r     <= 1'b0;
         case (ps_r)
            IDLE: begin
               if (start_p) begin
                  ps_r       <= ISSUE;
                  chal_vld_r <= 1'b1;
                  puf_en_r   <= EN_ONE << sel_r;
               end
            end
            ISSUE: begin
               ps_r <= WAIT;
            end
            WAIT: begin
               if (accept_s) begin
                  cnt_r[sel_r] <= inc_cnt_s;
                  if (final_s) begin
                     // sel stays on the last channel while halted
                     ps_r     <= HALT;
                     done_r   <= 1'b1;
                     puf_en_r <= '0;
                  end else begin
                     sel_r    <= sel_inc_s;
                     puf_en_r <= EN_ONE << sel_inc_s;
                     if (auto_mode) begin
                        ps_r       <= ISSUE;
                        chal_vld_r <= 1'b1;
                     end else begin
                        ps_r <= PAUSE;
                     end
                  end
               end
            end
            PAUSE: begin
               if (step_p || auto_mode) begin
                  ps_r       <= ISSUE;
                  chal_vld_r <= 1'b1;
               end
            end
            HALT: begin
               if (fsm_restart) begin
                  ps_r  <= IDLE;
                  sel_r <= '0;
                  for (int k = 0; k < N_PUF; k++) begin
                     cnt_r[k] <= '0;
                  end
               end
            end
            default: begin
               ps_r     <= IDLE;
               sel_r    <= '0;
               puf_en_r <= '0;
            end
         endcase
      end
   end

   // Flatten the per-channel counters onto the packed status port
   for (genvar g = 0; g < N_PUF; g++) begin : g_pack
      assign ch_cnt[g*CW +: CW] = cnt_r[g];
   end

   assign ps           = ps_r;
   assign done         = done_r;
   assign bus.sel      = sel_r;
   assign bus.puf_en   = puf_en_r;
   assign bus.chal_vld = chal_vld_r;
   assign bus.chal     = cnt_r[sel_r];

endmodule
